// File: rtl/maxpool_arbiter.sv
// Round-robin arbiter sharing one streaming maxpool engine among NREQ requesters.
// Accepted beats are tagged in order; the tag FIFO head routes each result back.
module maxpool_arbiter #(
    parameter int NREQ  = 4,
    parameter int R     = 4,
    parameter int W     = 8,
    parameter int BURST = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*R*W-1:0]      req_data,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [R/2*W-1:0]         rsp_data,
    output logic                     s_valid,
    input  logic                     s_ready,
    output logic [R*W-1:0]           s_data,
    input  logic                     m_valid,
    output logic                     m_ready,
    input  logic [R/2*W-1:0]         m_data,
    output logic [$clog2(NREQ)-1:0]  grant,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     err
);
    localparam int GW = $clog2(NREQ);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                   state;
    logic [GW-1:0]            rr, pick, head;
    logic [CW-1:0]            cnt;
    logic [GW-1:0]            tags [DEPTH];
    logic [AW-1:0]            wp, rp;
    logic [NREQ-1:0][R*W-1:0] req_vec;
    logic                     fifo_full, fifo_empty, push, pop, last_beat;

    // First requester with valid set, scanning upward from ptr+1 with wrap.
    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] ptr, input logic [NREQ-1:0] v);
        logic [GW-1:0] p, ki;
        int            k;
        p = ptr;
        for (int i = NREQ; i >= 1; i--) begin
            k  = (int'(ptr) + i) % NREQ;
            ki = GW'(k);
            if (v[ki]) p = ki;
        end
        return p;
    endfunction

    assign req_vec    = req_data;
    assign pick       = rr_pick(rr, req_valid);
    assign fifo_full  = inflight == (AW+1)'(DEPTH);
    assign fifo_empty = inflight == '0;
    assign head       = tags[rp];

    assign busy      = state == GRANT;
    assign s_valid   = busy && req_valid[grant] && !fifo_full;
    assign s_data    = req_vec[grant];
    assign push      = s_valid && s_ready;
    assign last_beat = push && cnt == CW'(BURST - 1);
    assign m_ready   = !fifo_empty && rsp_ready[head];
    assign pop       = m_valid && m_ready;
    assign rsp_data  = m_data;

    for (genvar n = 0; n < NREQ; n++) begin : g_req
        assign req_ready[n] = busy && grant == GW'(n) && s_ready && !fifo_full;
        assign rsp_valid[n] = !fifo_empty && head == GW'(n) && m_valid;
    end

    // A full FIFO with the owner still valid stalls in GRANT rather than releasing.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            rr    <= GW'(NREQ - 1);
            grant <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (push) cnt <= cnt + 1'b1;
                    if (last_beat || !req_valid[grant]) begin
                        state <= IDLE;
                        rr    <= grant;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp       <= '0;
            rp       <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
            if (m_valid && fifo_empty) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) tags[wp] <= grant;
    end
endmodule

// File: tb/tb_maxpool_arbiter.sv
// Randomized bench for maxpool_arbiter: queue-based reference model plus per-requester
// result scoreboard, with a behavioural maxpool engine supplying the return stream.
module tb_maxpool_arbiter;
    localparam int NREQ = 4, R = 4, W = 8, BURST = 4, DEPTH = 8;
    localparam int GW = $clog2(NREQ), IW = $clog2(DEPTH) + 1, DW = R * W, OW = R / 2 * W;

    logic clk = 1'b0, rstn = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [OW-1:0] rsp_data, m_data = '0;
    logic s_valid, s_ready = 1'b0, m_valid = 1'b0, m_ready, busy, err;
    logic [DW-1:0] s_data;
    logic [GW-1:0] grant;
    logic [IW-1:0] inflight;

    maxpool_arbiter #(.NREQ(NREQ), .R(R), .W(W), .BURST(BURST), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .grant(grant),
        .busy(busy), .inflight(inflight), .err(err));

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;

    // reference model state
    bit md_busy, md_err;
    int md_owner, md_rr, md_cnt;
    int tagq[$];
    logic [OW-1:0] expq[NREQ][$];
    // logs
    int glog[$], blog[$], dlog[$], beat_cyc[$];
    int max_infl;
    bit got_first;
    logic [OW-1:0] first_rsp;
    // handshakes seen before the coming edge
    bit hs_s, hs_m;
    logic [DW-1:0] hs_sdata;
    logic [NREQ-1:0] hs_acc;
    // stimulus knobs and engine
    int left[NREQ];
    logic [DW-1:0] dat[NREQ];
    int v_pct, sr_pct, lat;
    bit rsp_rand, inj;
    logic [NREQ-1:0] rr_fix;
    logic [OW-1:0] eq_d[$];
    int eq_t[$];

    function automatic logic [OW-1:0] pool(input logic [DW-1:0] d);
        logic [OW-1:0] o;
        logic [W-1:0] a, b;
        o = '0;
        for (int k = 0; k < R / 2; k++) begin
            a = d[2*k*W +: W];
            b = d[(2*k+1)*W +: W];
            o[k*W +: W] = (a > b) ? a : b;
        end
        return o;
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: checks every output against the model, then advances the model.
    bit full, empty, e_sv, e_mr, beat;
    int head;
    logic [NREQ-1:0] e_rr, e_rv;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstn) begin
                md_busy = 0; md_err = 0; md_owner = 0; md_rr = NREQ - 1; md_cnt = 0;
                tagq.delete();
                for (int n = 0; n < NREQ; n++) expq[n].delete();
                hs_s = 0; hs_m = 0; hs_acc = '0;
                chk("rst_outs", {req_ready, rsp_valid, s_valid, m_ready, busy, err}, '0);
                chk("rst_inflight", inflight, 0);
                chk("rst_grant", grant, 0);
            end else begin
                full  = tagq.size() == DEPTH;
                empty = tagq.size() == 0;
                head  = empty ? 0 : tagq[0];
                e_sv  = md_busy && req_valid[md_owner] && !full;
                e_rr  = '0;
                if (md_busy && s_ready && !full) e_rr[md_owner] = 1'b1;
                e_rv  = '0;
                if (!empty && m_valid) e_rv[head] = 1'b1;
                e_mr  = !empty && rsp_ready[head];
                chk("req_ready", req_ready, e_rr);
                chk("s_valid", s_valid, e_sv);
                chk("rsp_valid", rsp_valid, e_rv);
                chk("m_ready", m_ready, e_mr);
                chk("busy", busy, md_busy);
                chk("grant", grant, md_owner);
                chk("inflight", inflight, tagq.size());
                chk("err", err, md_err);
                if (e_sv) chk("s_data", s_data, req_data[md_owner*DW +: DW]);
                if (|e_rv) chk("rsp_data", rsp_data, m_data);
                for (int n = 0; n < NREQ; n++) begin
                    if (req_valid[n] && req_ready[n]) expq[n].push_back(pool(req_data[n*DW +: DW]));
                    if (rsp_valid[n] && rsp_ready[n]) begin
                        dlog.push_back(n);
                        if (n == 0 && !got_first) begin first_rsp = rsp_data; got_first = 1; end
                        chk("sb_underflow", expq[n].size() > 0, 1);
                        if (expq[n].size() > 0) chk("sb_data", rsp_data, expq[n].pop_front());
                    end
                end
                if (m_valid && empty) md_err = 1;
                if (!empty && m_valid && rsp_ready[head]) void'(tagq.pop_front());
                if (!md_busy) begin
                    for (int i = 1; i <= NREQ; i++) begin
                        if (req_valid[(md_rr + i) % NREQ]) begin
                            md_owner = (md_rr + i) % NREQ;
                            md_busy = 1; md_cnt = 0;
                            glog.push_back(md_owner); blog.push_back(0);
                            break;
                        end
                    end
                end else begin
                    beat = e_sv && s_ready;
                    if (beat) begin
                        tagq.push_back(md_owner);
                        md_cnt++;
                        if (blog.size() > 0) blog[blog.size()-1] = blog[blog.size()-1] + 1;
                        beat_cyc.push_back(cyc);
                    end
                    if ((beat && md_cnt == BURST) || !req_valid[md_owner]) begin
                        md_busy = 0; md_rr = md_owner;
                    end
                end
                hs_s = s_valid && s_ready; hs_sdata = s_data;
                hs_m = m_valid && m_ready;
                hs_acc = req_valid & req_ready;
                if (int'(inflight) > max_infl) max_infl = int'(inflight);
            end
        end
    end

    task automatic drive();
        if (!rstn) begin
            eq_d.delete(); eq_t.delete();
        end else begin
            if (hs_m && eq_d.size() > 0) begin void'(eq_d.pop_front()); void'(eq_t.pop_front()); end
            if (hs_s) begin eq_d.push_back(pool(hs_sdata)); eq_t.push_back(cyc + lat); end
        end
        for (int n = 0; n < NREQ; n++) begin
            if (hs_acc[n] && left[n] > 0) begin left[n]--; dat[n] = DW'($urandom); end
            req_valid[n] = (left[n] > 0) && ($urandom_range(0, 99) < v_pct);
            rsp_ready[n] = rsp_rand ? ($urandom_range(0, 99) < 60) : rr_fix[n];
            req_data[n*DW +: DW] = dat[n];
        end
        s_ready = $urandom_range(0, 99) < sr_pct;
        m_valid = inj || (eq_d.size() > 0 && eq_t[0] <= cyc);
        m_data  = (eq_d.size() > 0) ? eq_d[0] : OW'($urandom);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; drive(); end
    endtask

    task automatic defaults();
        v_pct = 100; sr_pct = 100; lat = 1; rsp_rand = 0; rr_fix = '1; inj = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk("async_rst_outs", {req_ready, rsp_valid, s_valid, m_ready, busy, err}, '0);
        chk("async_rst_inflight", inflight, 0);
        chk("async_rst_grant", grant, 0);
        eq_d.delete(); eq_t.delete();
        for (int n = 0; n < NREQ; n++) left[n] = 0;
        defaults();
        step(2);
        rstn = 1'b1;
        glog.delete(); blog.delete(); dlog.delete(); beat_cyc.delete();
        max_infl = 0; got_first = 0;
    endtask

    task automatic drain(input int maxc);
        int c, pend;
        defaults();
        c = 0;
        forever begin
            pend = 0;
            for (int n = 0; n < NREQ; n++) pend += left[n];
            if ((pend == 0 && inflight == 0 && eq_d.size() == 0) || c >= maxc) break;
            step(1); c++;
        end
        chk("drain_timeout", c < maxc, 1);
    endtask

    initial begin
        int exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_ooo[6] = '{0, 0, 0, 3, 3, 3};
        int c, rem;
        for (int n = 0; n < NREQ; n++) begin left[n] = 0; dat[n] = DW'($urandom); end
        defaults();
        #2;
        do_reset();

        // single requester, 6 beats in bursts of 4 + 2
        dat[0] = 32'h0305_2010;
        left[0] = 6;
        drain(100);
        chk("single_grants", glog.size(), 2);
        chk("single_g0_beats", qat(blog, 0), 4);
        chk("single_g1_beats", qat(blog, 1), 2);
        chk("single_b2b_gap", qat(beat_cyc, 1) - qat(beat_cyc, 0), 1);
        chk("single_idle_gap", qat(beat_cyc, 4) - qat(beat_cyc, 3), 2);
        chk("single_first_rsp", got_first ? first_rsp : 16'hxxxx, 16'h0520);
        chk("single_rsp_count", dlog.size(), 6);
        chk("single_inflight", inflight, 0);

        // round robin, everyone always valid
        do_reset();
        for (int n = 0; n < NREQ; n++) left[n] = 8;
        drain(400);
        chk("rr_grants", glog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_grant%0d", i), qat(glog, i), exp_rr[i]);
            chk($sformatf("rr_beats%0d", i), qat(blog, i), 4);
        end

        // early release by an idle owner
        do_reset();
        left[2] = 2;
        step(8);
        chk("early_first", qat(glog, 0), 2);
        left[1] = 1; left[3] = 1;
        drain(100);
        chk("early_next", qat(glog, 1), 3);
        chk("early_last", qat(glog, 2), 1);
        chk("early_beats", qat(blog, 0), 2);

        // backpressure: results for req 1 held, FIFO saturates
        do_reset();
        rr_fix[1] = 1'b0;
        left[1] = 10;
        step(30);
        chk("bp_max_inflight", max_infl, DEPTH);
        chk("bp_inflight", inflight, DEPTH);
        chk("bp_busy", busy, 1);
        chk("bp_grant", grant, 1);
        chk("bp_s_valid", s_valid, 0);
        drain(200);
        chk("bp_delivered", dlog.size(), 10);

        // head-of-line: req 0 results blocked, req 3 must wait behind them
        do_reset();
        rr_fix = 4'b1110;
        left[0] = 3; left[3] = 3;
        step(30);
        chk("ooo_none_yet", dlog.size(), 0);
        chk("ooo_inflight", inflight, 6);
        drain(200);
        for (int i = 0; i < 6; i++) chk($sformatf("ooo_order%0d", i), qat(dlog, i), exp_ooo[i]);

        // stray result with empty FIFO, then reset mid-burst
        do_reset();
        inj = 1;
        step(1);
        inj = 0;
        step(3);
        chk("err_set", err, 1);
        step(5);
        chk("err_sticky", err, 1);
        left[2] = 8;
        c = 0;
        while (!(busy && inflight > 0) && c < 20) begin step(1); c++; end
        chk("midburst_reached", c < 20, 1);
        do_reset();
        left[0] = 1; left[2] = 1;
        step(4);
        chk("post_rst_grant", qat(glog, 0), 0);
        drain(100);

        // random traffic
        do_reset();
        for (int n = 0; n < NREQ; n++) left[n] = $urandom_range(10, 40);
        rsp_rand = 1; v_pct = 75; sr_pct = 70;
        repeat (800) begin lat = $urandom_range(1, 3); step(1); end
        drain(2000);
        rem = 0;
        for (int n = 0; n < NREQ; n++) rem += expq[n].size();
        chk("rand_all_delivered", rem, 0);
        chk("rand_no_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/maxpool_arbiter.md
Name: maxpool_arbiter

Overview:
- Shares one streaming maxpool engine (R-lane in, R/2-lane out, valid/ready on both sides) between NREQ requester streams.
- Grants the engine round-robin in bursts of up to BURST beats.
- Tags every accepted beat with its requester index in an in-order tag FIFO, and uses the FIFO head to route each engine result back to the requester that issued it.
- Sits between the feature-map fetch channels and the single maxpool instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- R, 4, lanes per input beat (even)
- W, 8, bits per lane
- BURST, 4, maximum beats per grant (>=1)
- DEPTH, 8, tag FIFO depth: maximum beats in flight inside the engine (power of 2)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester input valid
- req_ready  out  NREQ  per-requester input ready
- req_data  in  NREQ*R*W  requester n data at [n*R*W +: R*W]; lane r at [r*W +: W]
- rsp_valid  out  NREQ  per-requester result valid
- rsp_ready  in  NREQ  per-requester result ready
- rsp_data  out  R/2*W  result data, shared by all requesters
- s_valid  out  1  to engine input valid
- s_ready  in  1  from engine input ready
- s_data  out  R*W  to engine input data
- m_valid  in  1  from engine result valid
- m_ready  out  1  to engine result ready
- m_data  in  R/2*W  from engine result data
- grant  out  $clog2(NREQ)  current owner index
- busy  out  1  high in GRANT state
- inflight  out  $clog2(DEPTH)+1  tag FIFO occupancy
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, rr pointer=NREQ-1 (requester 0 wins first), beat count=0, FIFO empty.
  - grant=0, busy=0, inflight=0, err=0.
  - All req_ready=0, rsp_valid=0, s_valid=0, m_ready=0.
  - Reset mid-burst discards all tags; results still inside the engine are not routed.
- State IDLE:
  - If any req_valid is high, pick the first requester with req_valid=1 searching from rr+1 modulo NREQ; register it as grant; go to GRANT with count=0.
  - No data transfers in IDLE. Each grant costs one arbitration cycle.
- State GRANT, owner g:
  - s_valid = req_valid[g] & !fifo_full.
  - req_ready[g] = s_ready & !fifo_full; req_ready for every other requester is 0.
  - s_data = req_data[g].
  - Beat = s_valid & s_ready. On a beat: push tag g, count++.
  - Exit to IDLE with rr=g when either:
    - a beat occurs with count==BURST-1, or
    - req_valid[g]=0 for a cycle (idle requester releases the grant).
  - FIFO full with req_valid[g]=1 holds the grant (stall, no release).
- Return path (independent of state):
  - head = tag at the FIFO read pointer.
  - When FIFO is non-empty:
    - rsp_valid[head] = m_valid; all other rsp_valid=0.
    - m_ready = rsp_ready[head].
    - rsp_data = m_data.
  - Pop on m_valid & m_ready.
  - When FIFO is empty: m_ready=0. If m_valid=1 in that case, set err (sticky until reset).
- FIFO rules:
  - A push while full is impossible by construction (s_valid is gated).
  - Simultaneous push and pop while not full: occupancy unchanged.
  - Simultaneous push and pop while full: the push is blocked; only the pop occurs.
  - Pointers wrap modulo DEPTH.
- The engine is in-order; data is never altered by this block.
- grant holds its last value in IDLE. busy=1 only in GRANT.

Test Plan:
- Single requester: NREQ=4, BURST=4. req 0 sends 6 beats back-to-back, rsp_ready=1. Beat 0 lanes {0x10,0x20,0x05,0x03} -> rsp_valid[0] with rsp_data={0x20,0x05}. Beats 0-3 are in grant 1 and beats 4-5 in grant 2, separated by one IDLE cycle. inflight returns to 0.
- Round robin: all 4 requesters always valid, 2 grants each. grant sequence 0,1,2,3,0,1,2,3, each exactly 4 beats. Every rsp goes only to the issuing index, in order.
- Early release: req 2 valid for 2 beats then drops. Grant released after the idle cycle, rr=2. Next contender req 1 and req 3 -> req 3 granted.
- Backpressure: rsp_ready[1]=0 while req 1 streams 10 beats, engine with 1-cycle latency. inflight saturates at 8 (s_valid low, grant held). Raising rsp_ready drains in order and streaming resumes.
- Out-of-order risk: results to req 0 and req 3 interleaved with rsp_ready[0]=0. Head tag 0 blocks m_ready, so no req 3 result is delivered before the pending req 0 result.
- Error/reset: inject m_valid with FIFO empty -> err=1 and stays 1. Assert rstn=0 mid-burst -> all outputs 0 immediately, err cleared, next grant goes to requester 0.
